// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between hazard/decode logic and the fetch sequencer.
// The requester side (decode, hazard unit, memory, mul/div) uses the master
// modport; the sequencer itself uses the slave modport.
interface fetch_sequencer_if #(
  parameter int PERF_W = 16
);
  logic              ld_use_hazard;
  logic              ctrl_xfer;
  logic              mem_busy;
  logic              muldiv_start;
  logic              halt_req;
  logic              resume;
  logic              pc_enable;
  logic              is_nop;
  logic              flush_ifid;
  logic              stall_ifid;
  logic              halted;
  logic [PERF_W-1:0] stall_count;
  logic [PERF_W-1:0] flush_count;

  modport master (
    output ld_use_hazard, ctrl_xfer, mem_busy, muldiv_start, halt_req, resume,
    input  pc_enable, is_nop, flush_ifid, stall_ifid, halted,
           stall_count, flush_count
  );

  modport slave (
    input  ld_use_hazard, ctrl_xfer, mem_busy, muldiv_start, halt_req, resume,
    output pc_enable, is_nop, flush_ifid, stall_ifid, halted,
           stall_count, flush_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Central stall/flush sequencer for the fetch stage. Turns hazard, memory
// wait, multiply/divide and halt requests into the PC enable, the IF/ID
// flush/stall strobes and a registered bubble marker, and keeps saturating
// stall/flush performance counters.
module fetch_sequencer #(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    HOLD,
    RUN,
    LSTALL,
    MEMW,
    MULDIV,
    HALT
  } state_t;

  // The issue cycle already counts as one stall cycle, so the down-counter
  // starts one below the total latency.
  localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MULDIV_LAT - 1);

  state_t            state;
  logic [CNT_W-1:0]  md_cnt;
  logic              is_nop_q;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt;

  logic pc_enable_c;
  logic flush_c;
  logic stall_c;

  // Combinational strobes from the current state and this cycle's requests.
  always_comb begin
    pc_enable_c = 1'b0;
    flush_c     = 1'b0;
    stall_c     = 1'b0;
    case (state)
      HOLD: begin
        pc_enable_c = 1'b0;
      end
      RUN: begin
        if (bus.halt_req | bus.mem_busy | bus.muldiv_start | bus.ld_use_hazard) begin
          stall_c = 1'b1;
        end else begin
          pc_enable_c = 1'b1;
          flush_c     = bus.ctrl_xfer;
        end
      end
      LSTALL: begin
        pc_enable_c = 1'b0;
      end
      MEMW: begin
        pc_enable_c = ~bus.mem_busy;
        stall_c     = bus.mem_busy;
      end
      MULDIV: begin
        if (md_cnt == '0) begin
          pc_enable_c = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end
      HALT: begin
        stall_c = 1'b1;
      end
      default: begin
        pc_enable_c = 1'b0;
      end
    endcase
    if (!rst_n) begin
      pc_enable_c = 1'b0;
      flush_c     = 1'b0;
      stall_c     = 1'b0;
    end
  end

  // State machine, latency counter, bubble marker and perf counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= HOLD;
      md_cnt    <= '0;
      is_nop_q  <= 1'b1;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      is_nop_q <= flush_c | (state == LSTALL) | (state == HOLD);
      if ((state != HOLD) && !pc_enable_c && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + PERF_W'(1);
      end
      if (flush_c && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + PERF_W'(1);
      end
      case (state)
        HOLD: begin
          state <= RUN;
        end
        RUN: begin
          if (bus.halt_req) begin
            state <= HALT;
          end else if (bus.mem_busy) begin
            state <= MEMW;
          end else if (bus.muldiv_start) begin
            md_cnt <= MD_INIT;
            state  <= MULDIV;
          end else if (bus.ld_use_hazard) begin
            state <= LSTALL;
          end
        end
        LSTALL: begin
          state <= RUN;
        end
        MEMW: begin
          if (!bus.mem_busy) begin
            state <= RUN;
          end
        end
        MULDIV: begin
          if (md_cnt == '0) begin
            state <= RUN;
          end else begin
            md_cnt <= md_cnt - CNT_W'(1);
          end
        end
        HALT: begin
          if (bus.resume) begin
            state <= RUN;
          end
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

  assign bus.pc_enable   = pc_enable_c;
  assign bus.flush_ifid  = flush_c;
  assign bus.stall_ifid  = stall_c;
  assign bus.is_nop      = is_nop_q;
  assign bus.halted      = (state == HALT);
  assign bus.stall_count = stall_cnt;
  assign bus.flush_count = flush_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a random
// soak, all compared against a behavioural model of the sequencing rules.
module tb_fetch_sequencer;

  localparam int LAT = 4;
  localparam int CW  = 6;
  localparam int PW  = 4;
  localparam int SAT = (1 << PW) - 1;
  localparam int VW  = 5 + 2 * PW;

  logic clk = 1'b0;
  logic rst_n;

  fetch_sequencer_if #(.PERF_W(PW)) bus ();

  fetch_sequencer #(
    .MULDIV_LAT(LAT),
    .CNT_W     (CW),
    .PERF_W    (PW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Behavioural model: which kind of pause the fetch stage is in.
  bit m_hold, m_bubble, m_memw, m_md, m_halt, m_nop;
  int m_elapsed, m_stalls, m_flushes;
  bit e_pe, e_fl, e_st;
  logic [VW-1:0] obs_vec, exp_vec;

  function automatic logic [PW-1:0] sat(input int v);
    return PW'((v > SAT) ? SAT : v);
  endfunction

  // Expected strobes for this cycle from the model and current requests.
  task automatic model_eval;
    e_pe = 1'b0;
    e_fl = 1'b0;
    e_st = 1'b0;
    if (!rst_n || m_hold || m_bubble) begin
      e_pe = 1'b0;
    end else if (m_halt) begin
      e_st = 1'b1;
    end else if (m_memw) begin
      e_pe = !bus.mem_busy;
      e_st = bus.mem_busy;
    end else if (m_md) begin
      if (m_elapsed < LAT) e_st = 1'b1;
      else e_pe = 1'b1;
    end else if (bus.halt_req || bus.mem_busy || bus.muldiv_start || bus.ld_use_hazard) begin
      e_st = 1'b1;
    end else begin
      e_pe = 1'b1;
      e_fl = bus.ctrl_xfer;
    end
  endtask

  // Model update at the clock edge.
  task automatic model_advance;
    if (!rst_n) begin
      m_hold = 1; m_bubble = 0; m_memw = 0; m_md = 0; m_halt = 0;
      m_nop = 1; m_elapsed = 0; m_stalls = 0; m_flushes = 0;
      return;
    end
    if (!m_hold && !e_pe) m_stalls++;
    if (e_fl) m_flushes++;
    m_nop = e_fl | m_bubble | m_hold;
    if (m_hold) m_hold = 0;
    else if (m_halt) begin if (bus.resume) m_halt = 0; end
    else if (m_bubble) m_bubble = 0;
    else if (m_memw) begin if (!bus.mem_busy) m_memw = 0; end
    else if (m_md) begin
      m_elapsed++;
      if (m_elapsed > LAT) m_md = 0;
    end else if (bus.halt_req) m_halt = 1;
    else if (bus.mem_busy) m_memw = 1;
    else if (bus.muldiv_start) begin m_md = 1; m_elapsed = 1; end
    else if (bus.ld_use_hazard) m_bubble = 1;
  endtask

  // Apply one cycle of inputs just after the falling edge, then sample.
  task automatic drive(input bit rn, ld, cx, mb, md, hr, rs);
    @(negedge clk);
    rst_n             = rn;
    bus.ld_use_hazard = ld;
    bus.ctrl_xfer     = cx;
    bus.mem_busy      = mb;
    bus.muldiv_start  = md;
    bus.halt_req      = hr;
    bus.resume        = rs;
    #1;
    model_eval();
    obs_vec = {bus.pc_enable, bus.flush_ifid, bus.stall_ifid, bus.is_nop,
               bus.halted, bus.stall_count, bus.flush_count};
    exp_vec = {e_pe, e_fl, e_st, m_nop, m_halt, sat(m_stalls), sat(m_flushes)};
  endtask

  task automatic tick;
    @(posedge clk);
    model_advance();
  endtask

  function automatic bit rb(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic do_reset;
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      drive(0, rb(50), rb(50), rb(50), rb(50), rb(50), rb(50));
      total++;
      if (i == 0) begin
        if ({bus.pc_enable, bus.flush_ifid, bus.stall_ifid} !== 3'b000)
          $display("[TB] FAIL reset_strobes got %b want 000",
                   {bus.pc_enable, bus.flush_ifid, bus.stall_ifid});
        else passed++;
      end else begin
        if (obs_vec !== exp_vec)
          $display("[TB] FAIL reset_vec cyc %0d got %h want %h", i, obs_vec, exp_vec);
        else passed++;
      end
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    total++;
    if (bus.pc_enable !== 1'b0 || bus.is_nop !== 1'b1)
      $display("[TB] FAIL reset_hold pc_enable=%b is_nop=%b want 0 1", bus.pc_enable, bus.is_nop);
    else passed++;
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    total++;
    if (bus.pc_enable !== 1'b1 || bus.is_nop !== 1'b1 || bus.stall_count !== '0 || bus.flush_count !== '0)
      $display("[TB] FAIL reset_run got pe=%b nop=%b sc=%0d fc=%0d want 1 1 0 0",
               bus.pc_enable, bus.is_nop, bus.stall_count, bus.flush_count);
    else passed++;
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs_vec !== exp_vec) $display("[TB] FAIL reset_after got %h want %h", obs_vec, exp_vec);
    else passed++;
    tick();
  endtask

  task automatic test_load_use;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, (i == 0), 0, 0, 0, 0, 0);
      total++;
      if (obs_vec !== exp_vec) $display("[TB] FAIL load_use cyc %0d got %h want %h", i, obs_vec, exp_vec);
      else passed++;
      if (i == 2) begin
        total++;
        if (bus.is_nop !== 1'b1 || bus.pc_enable !== 1'b1)
          $display("[TB] FAIL load_use_bubble is_nop=%b pe=%b want 1 1", bus.is_nop, bus.pc_enable);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_branch_flush;
    bit cx_seq[5] = '{1, 0, 1, 0, 0};
    bit mb_seq[5] = '{0, 0, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, cx_seq[i], mb_seq[i], 0, 0, 0);
      total++;
      if (obs_vec !== exp_vec) $display("[TB] FAIL branch cyc %0d got %h want %h", i, obs_vec, exp_vec);
      else passed++;
      if (i == 1) begin
        total++;
        if (bus.is_nop !== 1'b1 || bus.flush_count !== PW'(1))
          $display("[TB] FAIL branch_nop is_nop=%b fc=%0d want 1 1", bus.is_nop, bus.flush_count);
        else passed++;
      end
      if (i == 2) begin
        total++;
        if (bus.flush_ifid !== 1'b0 || bus.stall_ifid !== 1'b1)
          $display("[TB] FAIL branch_prio flush=%b stall=%b want 0 1", bus.flush_ifid, bus.stall_ifid);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_muldiv;
    int lows = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, (i >= 1 && i <= 4) ? rb(50) : 1'b0, 0, 0, (i == 0), 0, 0);
      total++;
      if (obs_vec !== exp_vec) $display("[TB] FAIL muldiv cyc %0d got %h want %h", i, obs_vec, exp_vec);
      else passed++;
      if (bus.pc_enable === 1'b0) lows++;
      tick();
    end
    total++;
    if (lows !== LAT) $display("[TB] FAIL muldiv_len got %0d want %0d", lows, LAT);
    else passed++;
  endtask

  task automatic test_mem_halt;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (i < 5)       drive(1, 0, 0, 1, 0, 0, 0);
      else if (i == 5) drive(1, 0, 0, 0, 0, 0, 0);
      else if (i == 6) drive(1, 0, 0, 0, 0, 1, 0);
      else if (i < 13) drive(1, rb(50), rb(50), rb(50), rb(50), rb(50), 0);
      else if (i == 13) drive(1, 0, 0, 0, 0, 0, 1);
      else             drive(1, 0, 0, 0, 0, 0, 0);
      total++;
      if (obs_vec !== exp_vec) $display("[TB] FAIL mem_halt cyc %0d got %h want %h", i, obs_vec, exp_vec);
      else passed++;
      if (i >= 7 && i <= 13) begin
        total++;
        if (bus.halted !== 1'b1 || bus.pc_enable !== 1'b0)
          $display("[TB] FAIL halt_hold cyc %0d halted=%b pe=%b want 1 0", i, bus.halted, bus.pc_enable);
        else passed++;
      end
      tick();
    end
    total++;
    if (bus.halted !== 1'b0 || bus.pc_enable !== 1'b1)
      $display("[TB] FAIL halt_exit halted=%b pe=%b want 0 1", bus.halted, bus.pc_enable);
    else passed++;
  endtask

  task automatic test_reset_mid_muldiv;
    int lows = 0;
    do_reset();
    drive(1, 0, 0, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs_vec !== exp_vec) $display("[TB] FAIL mid_reset got %h want %h", obs_vec, exp_vec);
    else passed++;
    tick();
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    total++;
    if (bus.pc_enable !== 1'b1 || bus.stall_count !== '0)
      $display("[TB] FAIL mid_reset_run pe=%b sc=%0d want 1 0", bus.pc_enable, bus.stall_count);
    else passed++;
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, (i == 0), 0, 0);
      if (bus.pc_enable === 1'b0) lows++;
      tick();
    end
    total++;
    if (lows !== LAT) $display("[TB] FAIL mid_reset_muldiv got %0d want %0d", lows, LAT);
    else passed++;
  endtask

  task automatic test_saturation;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 1, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    total++;
    if (bus.stall_count !== PW'(SAT)) $display("[TB] FAIL stall_sat got %0d want %0d", bus.stall_count, SAT);
    else passed++;
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs_vec !== exp_vec || bus.flush_count !== PW'(SAT))
      $display("[TB] FAIL flush_sat got %h want %h", obs_vec, exp_vec);
    else passed++;
    tick();
  endtask

  task automatic test_random;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(!rb(3), rb(15), rb(30), rb(25), rb(10), rb(5), rb(30));
      total++;
      if (obs_vec !== exp_vec) $display("[TB] FAIL random cyc %0d got %h want %h", i, obs_vec, exp_vec);
      else passed++;
      total++;
      if ((bus.flush_ifid & bus.stall_ifid) !== 1'b0 || (bus.flush_ifid & ~bus.pc_enable) !== 1'b0)
        $display("[TB] FAIL random_inv cyc %0d flush=%b stall=%b pe=%b",
                 i, bus.flush_ifid, bus.stall_ifid, bus.pc_enable);
      else passed++;
      tick();
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.ld_use_hazard = 1'b0;
    bus.ctrl_xfer     = 1'b0;
    bus.mem_busy      = 1'b0;
    bus.muldiv_start  = 1'b0;
    bus.halt_req      = 1'b0;
    bus.resume        = 1'b0;
    test_reset();
    test_load_use();
    test_branch_flush();
    test_muldiv();
    test_mem_halt();
    test_reset_mid_muldiv();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
